// File: rtl/join_merge_pkg.sv
// rtl/join_merge_pkg.sv - mode encoding and default widths for join_merge_n
package join_merge_pkg;

    typedef enum logic [1:0] {
        JM_JOIN       = 2'b00,
        JM_JOIN_CTRL  = 2'b01,
        JM_MERGE_RR   = 2'b10,
        JM_MERGE_PRIO = 2'b11
    } jm_mode_e;

    localparam int JM_DEFAULT_DATA_WIDTH = 32;
    localparam int JM_DEFAULT_NUM_INPUTS = 4;

endpackage

// File: rtl/join_merge_n_rr_arbiter.sv
// rtl/join_merge_n_rr_arbiter.sv - round-robin / fixed-priority arbiter owning rr_q
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N-1:0]     req,
    input  logic             en_rr,
    input  logic             advance,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] rr_q;
    logic             found;
    int unsigned      pos;

    // Search upward from rr_q with wrap in round-robin mode, from 0 otherwise.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = 0;
        for (int k = 0; k < N; k++) begin
            pos = en_rr ? (int'(rr_q) + k) % N : k;
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                gnt_idx  = IDX_W'(pos);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rr_q <= '0;
        end else if (advance && found) begin
            rr_q <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/join_merge_n.sv
// rtl/join_merge_n.sv - N-input join/merge with control channel; JOIN_MERGE_N_OUT_REG_EN adds an output register
module join_merge_n
    import join_merge_pkg::*;
#(
    parameter  int DATA_WIDTH = JM_DEFAULT_DATA_WIDTH,
    parameter  int NUM_INPUTS = JM_DEFAULT_NUM_INPUTS,
    localparam int SEL_W      = $clog2(NUM_INPUTS)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  jm_mode_e                              mode_i,
    input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] din_i,
    input  logic [NUM_INPUTS-1:0]                 din_v_i,
    output logic [NUM_INPUTS-1:0]                 din_r_o,
    input  logic                                  cin_i,
    input  logic                                  cin_v_i,
    output logic                                  cin_r_o,
    output logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] dout_o,
    output logic [SEL_W-1:0]                      sel_o,
    output logic                                  cout_o,
    output logic                                  out_v_o,
    input  logic                                  out_r_i
);

    logic                                  is_merge;
    logic                                  is_ctrl;
    logic                                  is_rr;
    logic                                  all_v;
    logic                                  ctrl_ok;
    logic                                  fire;
    logic                                  load;
    logic [NUM_INPUTS-1:0]                 others_v;
    logic [NUM_INPUTS-1:0]                 gnt;
    logic [SEL_W-1:0]                      gnt_idx;
    logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] nxt_dout;
    logic [SEL_W-1:0]                      nxt_sel;
    logic                                  nxt_cout;

    assign is_merge = mode_i[1];
    assign is_ctrl  = (mode_i == JM_JOIN_CTRL);
    assign is_rr    = (mode_i == JM_MERGE_RR);
    assign all_v    = &din_v_i;
    assign ctrl_ok  = is_ctrl ? cin_v_i : 1'b1;
    assign fire     = is_merge ? |din_v_i : (all_v & ctrl_ok);

    rr_arbiter #(.N(NUM_INPUTS)) u_arb (
        .clk     (clk_i),
        .resetn  (rst_n_i),
        .req     (din_v_i),
        .en_rr   (is_rr),
        .advance (rst_n_i & is_rr & fire & load),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // A join channel may hand over its token only when every other party is valid too.
    always_comb begin
        others_v = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            others_v[i] = &(din_v_i | (NUM_INPUTS'(1) << i));
        end
    end

    always_comb begin
        nxt_dout = '0;
        nxt_sel  = '0;
        nxt_cout = 1'b0;
        if (is_merge) begin
            nxt_dout[0] = din_i[gnt_idx];
            nxt_sel     = gnt_idx;
            nxt_cout    = (gnt_idx != '0);
        end else begin
            nxt_dout = din_i;
            nxt_cout = cin_i;
        end
    end

    // Readies are held low during reset so nothing is consumed while the block is cleared.
    assign din_r_o = (rst_n_i && load) ? (is_merge ? gnt : (others_v & {NUM_INPUTS{ctrl_ok}})) : '0;
    assign cin_r_o = rst_n_i & load & is_ctrl & all_v;

`ifdef JOIN_MERGE_N_OUT_REG_EN
    assign load = !out_v_o | out_r_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_v_o <= 1'b0;
            dout_o  <= '0;
            sel_o   <= '0;
            cout_o  <= 1'b0;
        end else if (fire && load) begin
            out_v_o <= 1'b1;
            dout_o  <= nxt_dout;
            sel_o   <= nxt_sel;
            cout_o  <= nxt_cout;
        end else if (out_r_i) begin
            out_v_o <= 1'b0;
        end
    end
`else
    assign load    = out_r_i;
    assign out_v_o = rst_n_i & fire;
    assign dout_o  = rst_n_i ? nxt_dout : '0;
    assign sel_o   = rst_n_i ? nxt_sel : '0;
    assign cout_o  = rst_n_i & nxt_cout;
`endif

endmodule
